// File: rtl/ifetch.sv
// ifetch: instruction fetch stage; PC, memory request FSM and an in-order fetch queue feeding IF/ID.
// Define IFETCH_PREFETCH_EN for a 2-entry queue (fetch runs one ahead); default build holds 1 entry.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] IF_instruccion,
   output logic [31:0] IF_sum4pcout,
   output logic        IF_valid,
   input  logic        IF_ready
);

`ifdef IFETCH_PREFETCH_EN
   localparam logic [1:0] DEPTH = 2'd2;
`else
   localparam logic [1:0] DEPTH = 2'd1;
`endif

   localparam logic [1:0] FETCH   = 2'd0;
   localparam logic [1:0] HOLD    = 2'd1;
   localparam logic [1:0] DISCARD = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] instr_q [2];
   logic [31:0] instr_d [2];
   logic [31:0] pc4_q [2];
   logic [31:0] pc4_d [2];
   logic        push;
   logic        pop;
   logic        wr_idx;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;
   assign pop      = (count_q != 2'd0) && IF_ready;
   assign push     = (state_q == FETCH) && imem_ack && !redirect;

   assign imem_req       = (state_q == FETCH) && !rst;
   assign imem_addr      = pc_q;
   assign IF_valid       = (count_q != 2'd0);
   assign IF_instruccion = instr_q[0];
   assign IF_sum4pcout   = pc4_q[0];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      wr_idx  = 1'b0;
      if (redirect) begin
         count_d = '0;
         pc_d    = {redirect_pc[31:2], 2'b00};
         // An ack arriving with the redirect retires the outstanding request, so nothing stale remains.
         case (state_q)
            FETCH:   state_d = imem_ack ? FETCH : DISCARD;
            DISCARD: state_d = imem_ack ? FETCH : DISCARD;
            default: state_d = FETCH;
         endcase
      end else begin
         if (pop) begin
            instr_d[0] = instr_q[1];
            pc4_d[0]   = pc4_q[1];
            count_d    = count_q - 2'd1;
         end
         if (push) begin
            wr_idx          = count_d[0];
            instr_d[wr_idx] = imem_rdata;
            pc4_d[wr_idx]   = pc_plus4;
            count_d         = count_d + 2'd1;
            pc_d            = pc_plus4;
         end
         case (state_q)
            FETCH:   if (push && (count_d == DEPTH)) state_d = HOLD;
            HOLD:    if (count_d != DEPTH) state_d = FETCH;
            DISCARD: if (imem_ack) state_d = FETCH;
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         count_q <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            instr_q[i] <= '0;
            pc4_q[i]   <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: randomized scoreboard bench for ifetch with a variable-latency memory model.
// Expected queue contents and request/address behaviour come from a transaction-level model.
module tb_ifetch;

`ifdef IFETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] IF_instruccion;
   logic [31:0] IF_sum4pcout;
   logic        IF_valid;
   logic        IF_ready = 1'b0;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] instr;
   } entry_t;

   entry_t      sb[$];
   logic [31:0] exp_pc = '0;
   bit          stale = 1'b0;
   bit          just_reset = 1'b0;
   int          total = 0;
   int          bad = 0;

   bit          mem_busy = 1'b0;
   int          mem_lat = 0;
   logic [31:0] mem_addr = '0;

   int          k_lat_min = 0;
   int          k_lat_max = 0;
   int          k_ready = 1;
   int          k_redir_pct = 0;
   int          k_rst_permil = 0;
   bit          k_rst = 1'b1;
   bit          f_redir = 1'b0;
   logic [31:0] f_redir_pc = '0;

   ifetch #(.RESET_PC(TB_RESET_PC)) dut (
      .clk(clk),
      .rst(rst),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .IF_instruccion(IF_instruccion),
      .IF_sum4pcout(IF_sum4pcout),
      .IF_valid(IF_valid),
      .IF_ready(IF_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] rand_pc();
      case ($urandom_range(3))
         0:       return $urandom;
         1:       return $urandom & 32'h0000_00FF;
         2:       return 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
         default: return $urandom & 32'h0000_0FFF;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply the effect of the cycle that ends at this edge to the reference model.
   task automatic model_update();
      if (rst) begin
         sb.delete();
         exp_pc     = TB_RESET_PC;
         stale      = 1'b0;
         mem_busy   = 1'b0;
         just_reset = 1'b1;
      end else begin
         just_reset = 1'b0;
         if (imem_ack) begin
            if (!redirect && !stale) begin
               sb.push_back({exp_pc + 32'd4, mem_word(exp_pc)});
               exp_pc = exp_pc + 32'd4;
            end
            stale    = 1'b0;
            mem_busy = 1'b0;
         end else if (mem_busy) begin
            mem_lat--;
         end
         if (redirect) begin
            sb.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
            if (mem_busy) stale = 1'b1;
         end
      end
   endtask

   task automatic drive();
      #1;
      rst         = k_rst || (int'($urandom_range(999)) < k_rst_permil);
      redirect    = f_redir || (int'($urandom_range(99)) < k_redir_pct);
      redirect_pc = f_redir ? f_redir_pc : rand_pc();
      IF_ready    = (k_ready == 1) ? 1'b1 : (k_ready == 2) ? 1'b0 : (int'($urandom_range(99)) < 70);
      f_redir     = 1'b0;
      #1;
      if (rst) begin
         mem_busy = 1'b0;
         imem_ack = 1'b0;
      end else begin
         if (!mem_busy && imem_req === 1'b1) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_lat  = int'($urandom_range(k_lat_max, k_lat_min));
         end
         imem_ack = mem_busy && (mem_lat == 0);
      end
      imem_rdata = imem_ack ? mem_word(mem_addr) : $urandom;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      drive();
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      f_redir    = 1'b1;
      f_redir_pc = pc;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("imem_req_in_reset", 32'(imem_req), 32'd0);
      end else begin
         logic exp_req;
         exp_req = !stale && (sb.size() < DEPTH);
         chk("imem_req", 32'(imem_req), 32'(exp_req));
         if (imem_req === 1'b1 && exp_req) chk("imem_addr", imem_addr, exp_pc);
         chk("IF_valid", 32'(IF_valid), 32'(sb.size() != 0));
         if (just_reset) begin
            chk("instr_after_reset", IF_instruccion, 32'd0);
            chk("sum4_after_reset", IF_sum4pcout, 32'd0);
         end
         if (IF_valid === 1'b1 && sb.size() != 0) begin
            chk("IF_sum4pcout", IF_sum4pcout, sb[0].pc4);
            chk("IF_instruccion", IF_instruccion, sb[0].instr);
            if (IF_ready && !redirect) void'(sb.pop_front());
         end
      end
   end

   initial begin
      k_rst = 1'b1;
      repeat (3) step();
      k_rst = 1'b0;

      // Zero-latency memory, consumer always ready: back-to-back fetch from 0.
      k_lat_min = 0; k_lat_max = 0; k_ready = 1; k_redir_pct = 0;
      repeat (20) step();

      // Stall the consumer to fill the queue, then drain.
      k_rst = 1'b1; step(); k_rst = 1'b0;
      k_ready = 2;
      repeat (6) step();
      k_ready = 1;
      repeat (6) step();

      // Slow request at 0x100 redirected to 0x203 before its ack returns.
      redirect_to(32'h0000_0100); step();
      k_lat_min = 3; k_lat_max = 3;
      step();
      redirect_to(32'h0000_0203); step();
      k_lat_min = 0; k_lat_max = 0;
      repeat (8) step();

      // Redirect coincident with ack and pop.
      repeat (3) step();
      redirect_to(32'h0000_0040); step();
      repeat (5) step();

      // PC wrap at the top of the address space.
      redirect_to(32'hFFFF_FFFC); step();
      repeat (5) step();

      // Random traffic with periodic consumer stalls.
      k_lat_min = 0; k_lat_max = 3; k_redir_pct = 6; k_rst_permil = 5;
      for (int i = 0; i < 3000; i++) begin
         k_ready = ((i % 100) < 8) ? 2 : 0;
         step();
      end
      k_rst_permil = 0; k_redir_pct = 0; k_ready = 1;
      repeat (10) step();

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
